// File: rtl/row_data_loader.sv
// ---------------------------------------------------------------------------
// row_data_loader
//
// Parses a framed byte stream from the host link and turns it into 32-bit
// chunk writes for the LED controller. A packet is 67 bytes:
//   SYNC_BYTE, address byte {2'b00, panel[1:0], row[3:0]}, 64 data bytes,
//   checksum byte (XOR of the address byte and all 64 data bytes).
// Every four data bytes form one chunk, assembled big-endian and written
// with a one-cycle strobe. There are 16 chunks per row.
// A stalled packet is aborted after TIMEOUT idle cycles.
//
// Parameters
//   TIMEOUT    idle cycles tolerated mid-packet before the packet is aborted
//   SYNC_BYTE  packet start marker
//
// Ports
//   clk                  system clock
//   reset                synchronous, active-high reset
//   in_data              stream byte
//   in_valid             in_data valid
//   in_ready             byte accepted when in_valid & in_ready (1 after reset)
//   chunk_data           assembled chunk, held between writes
//   chunk_addr           chunk index within the row (0..15)
//   chunk_write_enable   one-cycle chunk write strobe
//   row_data_row_addr    target row, held from the address byte onward
//   row_data_panel_addr  target panel, held from the address byte onward
//   row_done             one-cycle pulse: packet complete, checksum good
//   frame_error          one-cycle pulse: bad address, bad checksum or timeout
//   error_count          saturating count of frame_error pulses
// ---------------------------------------------------------------------------
module row_data_loader #(
    parameter int unsigned TIMEOUT   = 1024,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] chunk_data,
    output logic [3:0]  chunk_addr,
    output logic        chunk_write_enable,
    output logic [3:0]  row_data_row_addr,
    output logic [1:0]  row_data_panel_addr,
    output logic        row_done,
    output logic        frame_error,
    output logic [7:0]  error_count
);

    localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned SHIFT_W  = 24;
    localparam int unsigned ERRCNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_CSUM = 2'd3
    } state_t;

    // Parser state
    state_t               state_q;
    logic [CNT_W-1:0]     byte_cnt_q;
    logic [SHIFT_W-1:0]   shift_q;
    logic [7:0]           csum_q;
    logic [TMO_W-1:0]     tmo_q;

    // Registered outputs
    logic                 in_ready_q;
    logic [31:0]          chunk_data_q;
    logic [3:0]           chunk_addr_q;
    logic                 chunk_we_q;
    logic [3:0]           row_q;
    logic [1:0]           panel_q;
    logic                 row_done_q;
    logic                 frame_error_q;
    logic [ERRCNT_W-1:0]  error_count_q;

    // Decoded conditions for the current cycle
    logic accept_c;
    logic tmo_hit_c;
    logic addr_bad_c;
    logic csum_bad_c;
    logic err_c;

    assign accept_c = in_valid & in_ready_q;

    // An accepted byte always beats the timeout in the same cycle.
    assign tmo_hit_c  = (state_q != S_IDLE) && !accept_c
                        && (tmo_q == TMO_W'(TIMEOUT - 1));
    assign addr_bad_c = accept_c && (state_q == S_ADDR) && (in_data[7:6] != 2'b00);
    assign csum_bad_c = accept_c && (state_q == S_CSUM) && (in_data != csum_q);
    assign err_c      = tmo_hit_c | addr_bad_c | csum_bad_c;

    // Parser FSM, timeout counter and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            byte_cnt_q    <= '0;
            shift_q       <= '0;
            csum_q        <= '0;
            tmo_q         <= '0;
            in_ready_q    <= 1'b0;
            chunk_data_q  <= '0;
            chunk_addr_q  <= '0;
            chunk_we_q    <= 1'b0;
            row_q         <= '0;
            panel_q       <= '0;
            row_done_q    <= 1'b0;
            frame_error_q <= 1'b0;
            error_count_q <= '0;
        end else begin
            in_ready_q    <= 1'b1;
            chunk_we_q    <= 1'b0;
            row_done_q    <= 1'b0;
            frame_error_q <= err_c;

            // Idle-cycle counter only runs while a packet is in flight
            if ((state_q == S_IDLE) || accept_c || tmo_hit_c) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TMO_W'(1);
            end

            if (err_c && (error_count_q != {ERRCNT_W{1'b1}})) begin
                error_count_q <= error_count_q + ERRCNT_W'(1);
            end

            if (tmo_hit_c) begin
                state_q <= S_IDLE;
            end else if (accept_c) begin
                unique case (state_q)
                    S_IDLE: begin
                        if (in_data == SYNC_BYTE) begin
                            state_q <= S_ADDR;
                        end
                    end

                    S_ADDR: begin
                        if (addr_bad_c) begin
                            state_q <= S_IDLE;
                        end else begin
                            panel_q    <= in_data[5:4];
                            row_q      <= in_data[3:0];
                            byte_cnt_q <= '0;
                            csum_q     <= in_data;
                            state_q    <= S_DATA;
                        end
                    end

                    S_DATA: begin
                        // Only the last three bytes are needed to build a chunk
                        shift_q    <= {shift_q[SHIFT_W-9:0], in_data};
                        csum_q     <= csum_q ^ in_data;
                        byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                        if (byte_cnt_q[1:0] == 2'd3) begin
                            chunk_data_q <= {shift_q, in_data};
                            chunk_addr_q <= byte_cnt_q[5:2];
                            chunk_we_q   <= 1'b1;
                        end
                        if (byte_cnt_q == CNT_W'(63)) begin
                            state_q <= S_CSUM;
                        end
                    end

                    S_CSUM: begin
                        row_done_q <= ~csum_bad_c;
                        state_q    <= S_IDLE;
                    end

                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready            = in_ready_q;
    assign chunk_data          = chunk_data_q;
    assign chunk_addr          = chunk_addr_q;
    assign chunk_write_enable  = chunk_we_q;
    assign row_data_row_addr   = row_q;
    assign row_data_panel_addr = panel_q;
    assign row_done            = row_done_q;
    assign frame_error         = frame_error_q;
    assign error_count         = error_count_q;

endmodule

// File: tb/tb_row_data_loader.sv
// ---------------------------------------------------------------------------
// tb_row_data_loader
//
// Scoreboard bench for row_data_loader. The stimulus tasks push the expected
// chunk writes and packet outcomes into queues as bytes are driven; a monitor
// on the falling edge pops and compares them whenever the DUT strobes.
// ---------------------------------------------------------------------------
module tb_row_data_loader;

    localparam int unsigned TB_TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] chunk_data;
    logic [3:0]  chunk_addr;
    logic        chunk_write_enable;
    logic [3:0]  row_data_row_addr;
    logic [1:0]  row_data_panel_addr;
    logic        row_done;
    logic        frame_error;
    logic [7:0]  error_count;

    always #5 clk = ~clk;

    row_data_loader #(
        .TIMEOUT   (TB_TIMEOUT),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .in_data             (in_data),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .chunk_data          (chunk_data),
        .chunk_addr          (chunk_addr),
        .chunk_write_enable  (chunk_write_enable),
        .row_data_row_addr   (row_data_row_addr),
        .row_data_panel_addr (row_data_panel_addr),
        .row_done            (row_done),
        .frame_error         (frame_error),
        .error_count         (error_count)
    );

    typedef struct packed {
        logic [1:0]  panel;
        logic [3:0]  row;
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    localparam logic [1:0] EV_DONE = 2'b01;
    localparam logic [1:0] EV_ERR  = 2'b10;

    int checks   = 0;
    int failures = 0;

    wr_t        wq[$];
    logic [1:0] eq[$];
    logic [7:0] pkt[64];

    int cyc      = 0;
    int last_cyc = 0;
    int fe_cyc   = 0;
    int n_fe     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: compare every strobe against the queued expectation
    wr_t        mon_w;
    logic [1:0] mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            if (chunk_write_enable) begin
                if (wq.size() > 0) mon_w = wq.pop_front();
                else               mon_w = 'x;
                check_eq("chunk_write",
                         64'({row_data_panel_addr, row_data_row_addr, chunk_addr, chunk_data}),
                         64'(mon_w));
            end
            if (row_done || frame_error) begin
                if (eq.size() > 0) mon_e = eq.pop_front();
                else               mon_e = 'x;
                check_eq("packet_event", 64'({frame_error, row_done}), 64'(mon_e));
                if (frame_error) begin
                    fe_cyc = cyc;
                    n_fe++;
                end
            end
        end
    end

    function automatic int pick_gap(input int max_gap);
        if (max_gap <= 0) return 0;
        return int'($urandom_range(max_gap, 0));
    endfunction

    // Drive one byte after 'gap' idle cycles; it is accepted at the next edge
    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        last_cyc = cyc;
        in_valid = 1'b0;
    endtask

    // Send SYNC, address, n_data bytes of pkt[] and optionally the checksum.
    // long_at selects a data byte preceded by TIMEOUT-1 idle cycles (-1: none).
    task automatic send_pkt(input logic [7:0] addr, input int n_data, input bit do_csum,
                            input bit good, input int max_gap, input int long_at);
        logic [7:0]  x;
        logic [31:0] acc;
        wr_t         w;
        x   = addr;
        acc = '0;
        send_byte(8'hA5, pick_gap(max_gap));
        send_byte(addr, pick_gap(max_gap));
        for (int i = 0; i < n_data; i++) begin
            acc = {acc[23:0], pkt[i]};
            x   = x ^ pkt[i];
            if ((addr[7:6] == 2'b00) && ((i % 4) == 3)) begin
                w.panel = addr[5:4];
                w.row   = addr[3:0];
                w.addr  = 4'(i / 4);
                w.data  = acc;
                wq.push_back(w);
            end
            send_byte(pkt[i], (i == long_at) ? int'(TB_TIMEOUT) - 1 : pick_gap(max_gap));
        end
        if (do_csum) begin
            eq.push_back(good ? EV_DONE : EV_ERR);
            send_byte(good ? x : (x ^ 8'h27), pick_gap(max_gap));
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string tag);
        check_eq({tag, "_writes_left"}, 64'(wq.size()), 64'(0));
        check_eq({tag, "_events_left"}, 64'(eq.size()), 64'(0));
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({in_ready, chunk_data, chunk_addr, chunk_write_enable,
                    row_data_row_addr, row_data_panel_addr, row_done,
                    frame_error, error_count});
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int i = 0; i < 64; i++) pkt[i] = 8'(i);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outputs", all_outs(), 64'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("in_ready_after_reset", 64'(in_ready), 64'(1));

        // Two full-rate packets back to back
        send_pkt(8'h27, 64, 1'b1, 1'b1, 0, -1);
        send_pkt(8'h27, 64, 1'b1, 1'b1, 0, -1);
        settle();
        check_drained("full_rate");
        check_eq("full_rate_panel_row", 64'({row_data_panel_addr, row_data_row_addr}), 64'({2'd2, 4'd7}));
        check_eq("full_rate_last_chunk", 64'({chunk_addr, chunk_data}), 64'({4'd15, 32'h3C3D3E3F}));
        check_eq("full_rate_errcnt", 64'(error_count), 64'(0));

        // Bad checksum: writes still happen, one frame_error
        send_pkt(8'h27, 64, 1'b1, 1'b0, 0, -1);
        settle();
        check_drained("bad_csum");
        check_eq("bad_csum_errcnt", 64'(error_count), 64'(1));

        // Bad address byte followed at once by a good packet to another row
        eq.push_back(EV_ERR);
        send_pkt(8'h47, 0, 1'b0, 1'b0, 0, -1);
        settle();
        check_drained("bad_addr");
        check_eq("bad_addr_errcnt", 64'(error_count), 64'(2));
        check_eq("bad_addr_panel_row", 64'({row_data_panel_addr, row_data_row_addr}), 64'({2'd2, 4'd7}));
        for (int i = 0; i < 64; i++) pkt[i] = 8'($urandom);
        send_pkt(8'h3E, 64, 1'b1, 1'b1, 0, -1);
        settle();
        check_drained("after_bad_addr");
        check_eq("after_bad_addr_panel_row", 64'({row_data_panel_addr, row_data_row_addr}), 64'({2'd3, 4'd14}));

        // Timeout after data byte 10
        for (int i = 0; i < 64; i++) pkt[i] = 8'(i);
        n0 = n_fe;
        send_pkt(8'h27, 11, 1'b0, 1'b0, 0, -1);
        eq.push_back(EV_ERR);
        for (int i = 0; i < int'(TB_TIMEOUT) + 8 && n_fe == n0; i++) @(posedge clk);
        #1;
        check_eq("timeout_fired", 64'(n_fe - n0), 64'(1));
        check_eq("timeout_latency", 64'(fe_cyc - last_cyc), 64'(TB_TIMEOUT));
        settle();
        check_drained("timeout");
        check_eq("timeout_errcnt", 64'(error_count), 64'(3));
        send_pkt(8'h27, 64, 1'b1, 1'b1, 0, -1);
        settle();
        check_drained("after_timeout");

        // Garbage, then sparse valid with one TIMEOUT-1 gap mid-packet
        send_byte(8'h00, 0);
        send_byte(8'hFF, 2);
        send_pkt(8'h27, 64, 1'b1, 1'b1, 3, 20);
        settle();
        check_drained("sparse");
        check_eq("sparse_errcnt", 64'(error_count), 64'(3));

        // Reset mid-packet after data byte 20
        for (int i = 0; i < 64; i++) pkt[i] = 8'($urandom);
        send_pkt(8'h13, 21, 1'b0, 1'b0, 0, -1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midpkt_reset_outputs", all_outs(), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midpkt_in_ready", 64'(in_ready), 64'(1));
        send_pkt(8'h13, 64, 1'b1, 1'b1, 1, -1);
        settle();
        check_drained("after_reset");
        check_eq("after_reset_panel_row", 64'({row_data_panel_addr, row_data_row_addr}), 64'({2'd1, 4'd3}));
        check_eq("after_reset_errcnt", 64'(error_count), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/row_data_loader.md
# row_data_loader

Byte-stream packet parser that feeds the LED controller's chunk write port. Accepts a framed byte stream from the host link (valid/ready), assembles 32-bit chunks and issues one-cycle chunk writes with panel/row addressing, 16 chunks per row. Sits between the host interface and `led_controller`, driving `chunk_data`, `chunk_addr`, `chunk_write_enable`, `row_data_row_addr` and `row_data_panel_addr` directly.

## Interface
- `TIMEOUT`, default 1024: idle cycles allowed mid-packet before abort.
- `SYNC_BYTE`, default 8'hA5: packet start marker.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: byte accepted when `in_valid & in_ready`.
- `chunk_data` out 32: assembled chunk.
- `chunk_addr` out 4: chunk index within row, 0..15.
- `chunk_write_enable` out 1: one-cycle write strobe.
- `row_data_row_addr` out 4: target row.
- `row_data_panel_addr` out 2: target panel.
- `row_done` out 1: one-cycle pulse, packet complete and checksum good.
- `frame_error` out 1: one-cycle pulse, packet aborted or checksum bad.
- `error_count` out 8: saturating count of `frame_error` pulses.

## Operation
- Packet is 67 bytes: `SYNC_BYTE`, address byte, 64 data bytes, checksum byte.
- Address byte layout: [7:6] must be 2'b00, [5:4] panel, [3:0] row.
- Checksum is the XOR of the address byte and all 64 data bytes.
- States:
  - IDLE: discard bytes until `SYNC_BYTE`, then go to ADDR.
  - ADDR: if bits [7:6] are nonzero, pulse `frame_error` and go to IDLE. Otherwise latch panel/row into the address outputs, clear the byte counter, and go to DATA.
  - DATA: 6-bit byte counter b. Bytes shift in big-endian: first byte of a chunk lands in `chunk_data[31:24]`. When b[1:0]==3 is accepted, issue a write with `chunk_addr` = b[5:2]. After b==63, go to CSUM.
  - CSUM: compare against the running XOR. Match pulses `row_done`; mismatch pulses `frame_error`. Either way, go to IDLE.
- Chunks already written are not retracted on checksum failure or abort.
- `in_ready` = 1 in every state once out of reset. The block never back-pressures.
- Address outputs hold their value from ADDR until the next accepted ADDR byte; they are stable through all 16 writes.
- Timeout: a counter clears on every accepted byte and increments each cycle in ADDR/DATA/CSUM with no accepted byte. It does not run in IDLE.
  - On reaching `TIMEOUT`: pulse `frame_error` and go to IDLE.
  - If a byte is accepted in the same cycle the counter would expire, the byte wins and the timeout does not fire.
- `error_count` increments on every `frame_error` pulse and saturates at 255.
- A `SYNC_BYTE` value inside DATA/CSUM is treated as data and does not resync.

## Timing
- Reset: all outputs 0, including `in_ready`, `chunk_data`, both address outputs and `error_count`. State is IDLE, counters are 0.
- `in_ready` goes to 1 on the first cycle after `reset` deasserts.
- 4th byte of a chunk accepted at edge N: `chunk_write_enable` = 1 during the cycle after N, for exactly one cycle. `chunk_data` and `chunk_addr` are valid in that cycle and held until the next write.
- Address byte accepted at edge N: address outputs update in the cycle after N.
- Checksum byte accepted at edge N: `row_done` or `frame_error` = 1 during the cycle after N.
- Back-to-back packets at full rate are supported. A `SYNC_BYTE` accepted the cycle after the checksum byte starts a new packet.
- Minimum write spacing is 4 cycles. Maximum throughput is 1 byte/cycle.
- `reset` mid-packet: all outputs return to reset values on the next edge. No pulse is emitted and `error_count` clears.

## Test plan
- Full-rate packet: A5, 0x27, data bytes 0x00..0x3F, checksum 0x27^XOR(0..63)=0x27. Required: 16 writes with `chunk_addr` 0..15 and chunk k = {4k,4k+1,4k+2,4k+3}; panel=2, row=7; then `row_done` 1 cycle; `error_count`=0.
- Bad checksum: same packet with checksum 0x00. Required: all 16 writes still occur, `frame_error` pulses once, `error_count`=1, no `row_done`.
- Bad address byte 0x47. Required: `frame_error` pulse, no writes, state returns to IDLE, address outputs unchanged.
- Timeout: stop `in_valid` after data byte 10. Required: chunks 0 and 1 written; `frame_error` exactly `TIMEOUT` cycles after the last accepted byte; a following full packet completes with `row_done`.
- Garbage hunt and sparse valid: bytes 0x00, 0xFF, then a valid packet with `in_valid` toggled randomly. Required: garbage ignored, identical writes and `row_done`; a gap of `TIMEOUT`-1 cycles causes no error.
- Reset mid-packet after data byte 20. Required: all outputs 0 the next cycle, `error_count`=0, and a subsequent packet parses correctly.
